// File: rtl/mlaccel_sequencer_if.sv
// mlaccel_sequencer_if: command, shared-memory read and compute handshake bundle of the sequencer
//   master: sequencer side (drives busy, smem_valid/smem_addr, comp_valid/comp_insn)
//   slave:  command FSM, memory arbiter and compute unit side
interface mlaccel_sequencer_if;
  logic        start;
  logic [15:0] addr;
  logic        busy;
  logic        smem_valid;
  logic        smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        comp_valid;
  logic        comp_ready;
  logic [31:0] comp_insn;
  modport master(input start, addr, smem_ready, smem_data, comp_ready,
                 output busy, smem_valid, smem_addr, comp_valid, comp_insn);
  modport slave(output start, addr, smem_ready, smem_data, comp_ready,
                input busy, smem_valid, smem_addr, comp_valid, comp_insn);
endinterface

// File: rtl/mlaccel_sequencer.sv
// mlaccel_sequencer: fetches instructions from shared memory, runs control flow, forwards compute ops
//   clock/resetn: system clock, asynchronous active-low reset
//   bus: start/addr command, smem read request/response, comp valid/ready instruction handshake
module mlaccel_sequencer (
  input logic                 clock,
  input logic                 resetn,
  mlaccel_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ISSUE} state_t;
  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [31:0] insn;
  logic [15:0] stk [4];
  logic [2:0]  depth;
  logic [4:0]  op;
  logic [15:0] tgt, pc_inc;
  assign op     = insn[4:0];
  assign tgt    = insn[31:16];
  assign pc_inc = pc + 16'd1;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = bus.start ? FETCH : IDLE;
      FETCH: state_nxt = bus.smem_ready ? EXEC : FETCH;
      EXEC:  state_nxt = (op == 5'd0 || (op == 5'd3 && depth == 3'd0)) ? IDLE :
                         (op[4:3] != 2'd0) ? ISSUE : FETCH;
      ISSUE: state_nxt = bus.comp_ready ? FETCH : ISSUE;
    endcase
  end
  // Outputs are gated by state so everything reads zero outside the phase that owns it.
  always_comb begin
    bus.busy       = state != IDLE;
    bus.smem_valid = state == FETCH;
    bus.smem_addr  = (state == FETCH) ? pc : 16'd0;
    bus.comp_valid = state == ISSUE;
    bus.comp_insn  = (state == ISSUE) ? insn : 32'd0;
  end
  // Return stack is a shift register with stk[0] on top; a push when full drops stk[3], the oldest.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      pc    <= 16'd0;
      insn  <= 32'd0;
      depth <= 3'd0;
      for (int i = 0; i < 4; i++) stk[i] <= 16'd0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          pc    <= bus.addr;
          depth <= 3'd0;
        end
        FETCH: if (bus.smem_ready) insn <= bus.smem_data;
        EXEC:
          if (op == 5'd1) pc <= tgt;
          else if (op == 5'd2) begin
            pc     <= tgt;
            stk[0] <= pc_inc;
            for (int i = 1; i < 4; i++) stk[i] <= stk[i-1];
            depth  <= (depth == 3'd4) ? 3'd4 : depth + 3'd1;
          end else if (op == 5'd3 && depth != 3'd0) begin
            pc    <= stk[0];
            for (int i = 0; i < 3; i++) stk[i] <= stk[i+1];
            depth <= depth - 3'd1;
          end else if (op[4:2] == 3'd1) pc <= pc_inc;
        ISSUE: if (bus.comp_ready) pc <= pc_inc;
      endcase
    end
endmodule

// File: tb/tb_mlaccel_sequencer.sv
// tb_mlaccel_sequencer: random and directed programs checked against an instruction-level model
module tb_mlaccel_sequencer;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  mlaccel_sequencer_if bus();
  mlaccel_sequencer dut(.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  logic [31:0] mem [65536];
  int checks = 0;
  int errors = 0;
  int lat = 3;
  int stall = 0;
  int cnt, vcnt;
  bit served;
  logic [31:0] f_log[$], c_log[$], m_f[$], m_c[$];
  int k_log[$], m_k[$];
  bit m_halt, d_halt;
  int m_busy, d_bcyc, d_fcv;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // memory answers lat cycles after a request appears; stray ready pulses are injected when idle
  // compute accepts after stall cycles of comp_valid; random ready while comp_valid is low
  initial begin
    bus.smem_ready = 1'b0;
    bus.smem_data = 32'd0;
    bus.comp_ready = 1'b0;
    cnt = 0;
    vcnt = 0;
    served = 0;
    forever begin
      @(negedge clock);
      if (bus.smem_valid === 1'b1 && !served) begin
        if (cnt == lat) begin
          bus.smem_ready = 1'b1;
          bus.smem_data = mem[bus.smem_addr];
          f_log.push_back(32'(bus.smem_addr));
          served = 1;
        end else begin
          bus.smem_ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.smem_ready = ($urandom_range(0, 3) == 0);
        bus.smem_data = $urandom;
        cnt = 0;
        served = 0;
      end
      if (bus.comp_valid === 1'b1) begin
        bus.comp_ready = (vcnt >= stall);
        vcnt++;
        if (bus.comp_ready) begin
          c_log.push_back(bus.comp_insn);
          vcnt = 0;
        end
      end else begin
        bus.comp_ready = 1'($urandom_range(0, 1));
        vcnt = 0;
      end
    end
  end
  task automatic model(input logic [15:0] a, input int cap);
    logic [15:0] pc;
    logic [15:0] stk[$];
    logic [31:0] w;
    int t, op;
    pc = a;
    t = 1;
    m_f.delete(); m_c.delete(); m_k.delete();
    m_halt = 0;
    m_busy = 0;
    forever begin
      m_f.push_back(32'(pc));
      m_k.push_back(t);
      if (m_f.size() == cap) return;
      w = mem[pc];
      op = int'(w[4:0]);
      if (op == 0 || (op == 3 && stk.size() == 0)) begin
        m_halt = 1;
        m_busy = t + lat + 1;
        return;
      end
      if (op == 1) pc = w[31:16];
      else if (op == 2) begin
        stk.push_front(pc + 16'd1);
        if (stk.size() > 4) void'(stk.pop_back());
        pc = w[31:16];
      end else if (op == 3) pc = stk.pop_front();
      else begin
        pc = pc + 16'd1;
        if (op >= 8) begin
          m_c.push_back(w);
          t += stall + 1;
        end
      end
      t += lat + 2;
    end
  endtask
  task automatic run(input logic [15:0] a, input int cap, input int abort_k, input int poke_k,
                     input logic [2:0] exp_pre);
    bit sv_p, cv_p, hs_p, done;
    logic [31:0] ins_p;
    sv_p = 0; cv_p = 0; hs_p = 0; done = 0; ins_p = 0;
    f_log.delete(); c_log.delete(); k_log.delete();
    d_bcyc = 0; d_fcv = -1; d_halt = 0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.addr = a;
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 1; k <= 3000 && !done; k++) begin
      #1;
      bus.start = (k == poke_k);
      if (k == poke_k) bus.addr = 16'h0000;
      if (bus.smem_valid && !sv_p) k_log.push_back(k);
      if (bus.comp_valid && d_fcv < 0) d_fcv = k;
      if (cv_p && !hs_p && bus.comp_valid) begin
        chk("hold_insn", bus.comp_insn, ins_p);
        chk("hold_busy_nofetch", {30'd0, bus.smem_valid, bus.busy}, 32'd1);
      end
      if (bus.busy) d_bcyc++;
      if (!bus.busy) d_halt = 1;
      done = !bus.busy || f_log.size() == cap || k == abort_k;
      if (done && bus.busy) begin
        if (k == abort_k)
          chk("pre_abort", {29'd0, bus.busy, bus.smem_valid, bus.comp_valid}, {29'd0, exp_pre});
        resetn = 1'b0;
        #1;
        chk("rst_ctl_addr", {bus.busy, bus.smem_valid, bus.comp_valid, 13'd0, bus.smem_addr}, 32'd0);
        chk("rst_insn", bus.comp_insn, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
      end
      sv_p = bus.smem_valid;
      cv_p = bus.comp_valid;
      hs_p = bus.comp_valid && bus.comp_ready;
      ins_p = bus.comp_insn;
      if (!done) @(negedge clock);
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask
  task automatic go(input logic [15:0] a, input int abort_k, input int poke_k, input logic [2:0] exp_pre);
    model(a, 40);
    run(a, 40, abort_k, poke_k, exp_pre);
    if (abort_k == 0) begin
      chk("halted", 32'(d_halt), 32'(m_halt));
      chk("nfetch", f_log.size(), m_f.size());
      chk("ncomp", c_log.size(), m_c.size());
      if (m_halt) chk("busy_cycles", d_bcyc, m_busy);
    end
    foreach (f_log[i]) chk("fetch_addr", f_log[i], i < m_f.size() ? m_f[i] : 32'hFFFF_FFFF);
    foreach (k_log[i]) chk("fetch_cycle", k_log[i], i < m_k.size() ? m_k[i] : -1);
    foreach (c_log[i]) chk("comp_insn", c_log[i], i < m_c.size() ? m_c[i] : 32'hFFFF_FFFF);
  endtask
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'd0;
  endtask
  initial begin
    logic [15:0] base, tg;
    logic [31:0] nest [10];
    int r, op;
    bus.start = 1'b0;
    bus.addr = 16'd0;
    clear_mem();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_ctl_addr", {bus.busy, bus.smem_valid, bus.comp_valid, 13'd0, bus.smem_addr}, 32'd0);
    chk("reset_insn", bus.comp_insn, 32'd0);
    resetn = 1'b1;
    mem[16'h10] = 32'h0000_0008;
    go(16'h0010, 0, 0, 3'd0);
    chk("t1_addr0", f_log[0], 32'h10);
    chk("t1_addr1", f_log[1], 32'h11);
    chk("t1_insn", c_log[0], 32'h8);
    chk("t1_first_comp_valid", d_fcv, 6);
    chk("t1_second_fetch", k_log[1], 7);
    chk("t1_busy_cycles", d_bcyc, 11);
    clear_mem();
    mem[16'h0000] = 32'h0020_0001;
    go(16'h0000, 0, 0, 3'd0);
    chk("jump_target", f_log[1], 32'h20);
    clear_mem();
    mem[16'hFFFF] = 32'h0000_0004;
    go(16'hFFFF, 0, 0, 3'd0);
    chk("pc_wrap", f_log[1], 32'h0);
    clear_mem();
    mem[16'h0005] = 32'h0040_0002;
    mem[16'h0040] = 32'h0000_0003;
    mem[16'h0006] = 32'h0000_0003;
    go(16'h0005, 0, 0, 3'd0);
    chk("call_ret_addr", f_log[2], 32'h6);
    chk("ret_empty_halts", 32'(d_halt), 32'd1);
    clear_mem();
    for (int i = 0; i < 5; i++) mem[16'h100 * (i + 1)] = {16'(16'h100 * (i + 2)), 16'h0002};
    mem[16'h600] = 32'd3; mem[16'h501] = 32'd3; mem[16'h401] = 32'd3;
    mem[16'h301] = 32'd3; mem[16'h201] = 32'd3;
    nest = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h501, 32'h401, 32'h301, 32'h201};
    go(16'h0100, 0, 0, 3'd0);
    chk("nest_nfetch", f_log.size(), 10);
    for (int i = 0; i < 10; i++) chk("nest_addr", f_log[i], nest[i]);
    clear_mem();
    mem[16'h80] = 32'h1234_5689;
    stall = 10;
    go(16'h0080, 0, 10, 3'd0);
    chk("stall_insn", c_log[0], 32'h1234_5689);
    chk("stall_nfetch", f_log.size(), 2);
    clear_mem();
    mem[16'h10] = 32'h0000_0008;
    stall = 0;
    go(16'h0010, 2, 0, 3'b110);
    stall = 10;
    go(16'h0010, 9, 0, 3'b101);
    stall = 0;
    go(16'h0010, 0, 0, 3'd0);
    for (int n = 0; n < 40; n++) begin
      clear_mem();
      base = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : 16'($urandom);
      for (int i = 0; i < 32; i++) begin
        r = $urandom_range(0, 99);
        tg = base + 16'($urandom_range(0, 31));
        op = r < 8 ? 0 : r < 20 ? 1 : r < 35 ? 2 : r < 50 ? 3 :
             r < 58 ? $urandom_range(4, 7) : $urandom_range(8, 31);
        mem[16'(base + 16'(i))] = {tg, 11'($urandom), 5'(op)};
      end
      lat = $urandom_range(0, 4);
      stall = $urandom_range(0, 3);
      go(base, 0, 0, 3'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
